// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with per-slot blanking and PWM brightness.
// Every output is registered from the current state, counters and latched digit data.
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig_en,
  input  logic [3:0] bright,
  input  logic [6:0] disp0,
  input  logic [6:0] disp1,
  input  logic [6:0] disp2,
  input  logic [6:0] disp3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned ON_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;
  localparam logic [1:0] S_ON     = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;
  logic [ON_W-1:0]  on_cnt, on_cnt_nxt;
  logic [3:0]       pwm, pwm_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             first, first_nxt;
  logic [6:0]       hold_seg, hold_seg_nxt;
  logic             hold_dp, hold_dp_nxt;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic             frame_tick_nxt;

  logic [1:0]       sel_base;
  logic [1:0]       cand;
  logic [1:0]       pick;
  logic [6:0]       pick_seg;
  logic             pick_dp;
  logic             abort;

  // Next enabled digit after the current one (or from digit 0 on a fresh start), wrapping.
  always_comb begin
    sel_base = first ? 2'd0 : idx + 2'd1;
    pick     = sel_base;
    cand     = sel_base;
    for (int k = 3; k >= 0; k--) begin
      cand = sel_base + 2'(k);
      if (dig_en[cand]) pick = cand;
    end
  end

  always_comb begin
    pick_seg = disp0;
    case (pick)
      2'd0:    pick_seg = disp0;
      2'd1:    pick_seg = disp1;
      2'd2:    pick_seg = disp2;
      default: pick_seg = disp3;
    endcase
    pick_dp = dp_in[pick];
  end

  assign abort = !en || (dig_en == 4'd0);

  always_comb begin
    state_nxt      = state;
    blk_cnt_nxt    = blk_cnt;
    on_cnt_nxt     = on_cnt;
    pwm_nxt        = pwm;
    idx_nxt        = idx;
    first_nxt      = first;
    hold_seg_nxt   = hold_seg;
    hold_dp_nxt    = hold_dp;
    an_nxt         = 4'hF;
    seg_nxt        = 7'h7F;
    dp_nxt         = 1'b1;
    frame_tick_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        first_nxt = 1'b1;
        state_nxt = S_SELECT;
      end
      S_SELECT: begin
        idx_nxt        = pick;
        hold_seg_nxt   = pick_seg;
        hold_dp_nxt    = pick_dp;
        frame_tick_nxt = first || (pick <= idx);
        first_nxt      = 1'b0;
        blk_cnt_nxt    = '0;
        state_nxt      = S_BLANK;
      end
      S_BLANK: begin
        if (blk_cnt == BLK_W'(BLANK_CYC - 1)) begin
          on_cnt_nxt = '0;
          pwm_nxt    = 4'd0;
          state_nxt  = S_ON;
        end else begin
          blk_cnt_nxt = blk_cnt + BLK_W'(1);
        end
      end
      default: begin
        pwm_nxt = pwm + 4'd1;
        if (pwm < bright) begin
          an_nxt  = ~(4'b0001 << idx);
          seg_nxt = hold_seg;
          dp_nxt  = hold_dp;
        end
        if (on_cnt == ON_W'(SCAN_DIV - 1)) begin
          state_nxt = S_SELECT;
        end else begin
          on_cnt_nxt = on_cnt + ON_W'(1);
        end
      end
    endcase

    // Losing enable or all digits drops to IDLE; the next scan restarts at digit 0.
    if (abort) begin
      state_nxt      = S_IDLE;
      first_nxt      = 1'b1;
      frame_tick_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      blk_cnt    <= '0;
      on_cnt     <= '0;
      pwm        <= 4'd0;
      idx        <= 2'd0;
      first      <= 1'b1;
      hold_seg   <= 7'h7F;
      hold_dp    <= 1'b1;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      blk_cnt    <= blk_cnt_nxt;
      on_cnt     <= on_cnt_nxt;
      pwm        <= pwm_nxt;
      idx        <= idx_nxt;
      first      <= first_nxt;
      hold_seg   <= hold_seg_nxt;
      hold_dp    <= hold_dp_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a fast-slot instance (8/2) and a long-slot instance (32/2)
// share stimulus; expected windows are queued at stimulus time and popped as the DUT lights up.
module tb_disp_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] dig_en;
  logic [3:0] bright;
  logic [6:0] disp0, disp1, disp2, disp3;
  logic [3:0] dp_in;

  logic [3:0] an, an32;
  logic [6:0] seg, seg32;
  logic       dp, dp32;
  logic       frame_tick, ft32;

  int vec  = 0;
  int errs = 0;
  exp_t q[$];
  logic [6:0] pat [4];

  disp_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .dig_en(dig_en), .bright(bright),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  disp_scan_ctrl #(.SCAN_DIV(32), .BLANK_CYC(2)) u_dut32 (
    .clk(clk), .rst(rst), .en(en), .dig_en(dig_en), .bright(bright),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3), .dp_in(dp_in),
    .an(an32), .seg(seg32), .dp(dp32), .frame_tick(ft32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop en long enough to reach IDLE with blank outputs; caller raises en at edge 0.
  task automatic go_idle();
    en = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b0; dig_en = 4'b0000; bright = 4'd15;
    disp0 = 7'h40; disp1 = 7'h79; disp2 = 7'h24; disp3 = 7'h30; dp_in = 4'hF;
    #2 rst = 1'b1;
    step();
    step();
    vec++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset got an=%b seg=%h dp=%b ft=%b need 1111/7f/1/0", an, seg, dp, frame_tick);
    end
    vec++;
    if ({an32, seg32, dp32, ft32} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL reset32 got an=%b seg=%h dp=%b ft=%b need 1111/7f/1/0", an32, seg32, dp32, ft32);
    end
    rst = 1'b0;
    step();
  endtask

  // Single digit: cycle-exact output stream for the first two slots.
  task automatic test_single();
    exp_t got, ex;
    logic lit;
    go_idle();
    dig_en = 4'b0001; bright = 4'd15; disp0 = 7'h40; dp_in = 4'b1110;
    for (int e = 1; e <= 16; e++) begin
      lit = ((e >= 5) && (e <= 12)) || (e == 16);
      q.push_back('{an: lit ? 4'b1110 : 4'hF, seg: lit ? 7'h40 : 7'h7F,
                    dp: lit ? 1'b0 : 1'b1, ft: (e == 2) || (e == 13)});
    end
    en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      got = '{an: an, seg: seg, dp: dp, ft: frame_tick};
      ex  = q.pop_front();
      vec++;
      if (got !== ex) begin
        errs++;
        $display("FAIL single_e%0d got an=%b seg=%h dp=%b ft=%b need an=%b seg=%h dp=%b ft=%b",
                 e, got.an, got.seg, got.dp, got.ft, ex.an, ex.seg, ex.dp, ex.ft);
      end
    end
  endtask

  // Multi-digit scan: each lit window checked against the queued digit; ft marks a preceding tick.
  task automatic test_scan(input logic [3:0] mask, input int nwin, input int ncyc, input string name);
    exp_t got, ex;
    logic [3:0] prev_an;
    logic tick_seen;
    int viol;
    int d;
    int last;
    go_idle();
    dig_en = mask; bright = 4'd15;
    disp0 = 7'h40; disp1 = 7'h79; disp2 = 7'h24; disp3 = 7'h30; dp_in = 4'b1010;
    pat[0] = disp0; pat[1] = disp1; pat[2] = disp2; pat[3] = disp3;
    d = -1;
    last = -1;
    for (int w = 0; w < nwin; w++) begin
      for (int k = 1; k <= 4; k++) begin
        if (mask[(d + k) % 4]) begin
          d = (d + k) % 4;
          break;
        end
      end
      q.push_back('{an: ~(4'b0001 << d), seg: pat[d], dp: dp_in[d], ft: (w == 0) || (d <= last)});
      last = d;
    end
    en = 1'b1;
    prev_an = 4'hF;
    tick_seen = 1'b0;
    viol = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (frame_tick) tick_seen = 1'b1;
      if ($countones(~an) > 1) viol++;
      if (an != 4'hF && prev_an == 4'hF) begin
        vec++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL %s_extra got an=%b at cycle %0d need no window", name, an, c);
        end else begin
          got = '{an: an, seg: seg, dp: dp, ft: tick_seen};
          ex  = q.pop_front();
          if (got !== ex) begin
            errs++;
            $display("FAIL %s_win got an=%b seg=%h dp=%b ft=%b need an=%b seg=%h dp=%b ft=%b",
                     name, got.an, got.seg, got.dp, got.ft, ex.an, ex.seg, ex.dp, ex.ft);
          end
        end
        tick_seen = 1'b0;
      end
      prev_an = an;
    end
    vec++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL %s_missing got %0d windows left need 0", name, q.size());
    end
    q.delete();
    vec++;
    if (viol != 0) begin
      errs++;
      $display("FAIL %s_onehot got %0d multi-low cycles need 0", name, viol);
    end
  endtask

  // Lit-cycle count on the 32-cycle instance over three slots (edges 1..105).
  task automatic test_pwm(input logic [3:0] lvl, input int need);
    int lit;
    go_idle();
    dig_en = 4'b0001; bright = lvl;
    en = 1'b1;
    lit = 0;
    for (int c = 1; c <= 105; c++) begin
      step();
      if (an32 != 4'hF) lit++;
    end
    vec++;
    if (lit != need) begin
      errs++;
      $display("FAIL pwm_b%0d got %0d lit cycles need %0d", lvl, lit, need);
    end
  endtask

  // disp0 changed mid-slot must only show at the next digit-0 slot.
  task automatic test_hold();
    exp_t cur;
    logic [3:0] prev_an;
    go_idle();
    dig_en = 4'b0011; bright = 4'd15; disp0 = 7'h40; disp1 = 7'h79; dp_in = 4'hF;
    q.push_back('{an: 4'b1110, seg: 7'h40, dp: 1'b1, ft: 1'b0});
    q.push_back('{an: 4'b1101, seg: 7'h79, dp: 1'b1, ft: 1'b0});
    q.push_back('{an: 4'b1110, seg: 7'h24, dp: 1'b1, ft: 1'b0});
    cur = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
    en = 1'b1;
    prev_an = 4'hF;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (an != 4'hF && prev_an == 4'hF && q.size() != 0) cur = q.pop_front();
      if (an != 4'hF) begin
        vec++;
        if ({an, seg} !== {cur.an, cur.seg}) begin
          errs++;
          $display("FAIL hold_c%0d got an=%b seg=%h need an=%b seg=%h", c, an, seg, cur.an, cur.seg);
        end
      end
      prev_an = an;
      if (c == 7) disp0 = 7'h24;
    end
    vec++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL hold_missing got %0d windows left need 0", q.size());
    end
    q.delete();
  endtask

  // en dropped mid-ON: one more lit cycle (IDLE entry), then blank.
  task automatic test_en_drop();
    go_idle();
    dig_en = 4'b0001; bright = 4'd15; disp0 = 7'h40;
    en = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    en = 1'b0;
    step();
    vec++;
    if ({an, seg} !== {4'b1110, 7'h40}) begin
      errs++;
      $display("FAIL en_drop_e9 got an=%b seg=%h need an=1110 seg=40", an, seg);
    end
    step();
    vec++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL en_drop_e10 got an=%b seg=%h dp=%b need 1111/7f/1", an, seg, dp);
    end
  endtask

  // Reset mid-ON blanks without a clock edge; release restarts at digit 0 with full blanking.
  task automatic test_reset_mid();
    exp_t got, ex;
    go_idle();
    dig_en = 4'b1111; bright = 4'd15;
    disp0 = 7'h40; disp1 = 7'h79; disp2 = 7'h24; disp3 = 7'h30; dp_in = 4'hF;
    en = 1'b1;
    for (int c = 1; c <= 18; c++) step();
    vec++;
    if ({an, seg} !== {4'b1101, 7'h79}) begin
      errs++;
      $display("FAIL rstmid_pre got an=%b seg=%h need an=1101 seg=79", an, seg);
    end
    rst = 1'b1;
    #1;
    vec++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL rstmid_async got an=%b seg=%h dp=%b ft=%b need 1111/7f/1/0", an, seg, dp, frame_tick);
    end
    step();
    step();
    for (int e = 1; e <= 5; e++)
      q.push_back('{an: (e == 5) ? 4'b1110 : 4'hF, seg: (e == 5) ? 7'h40 : 7'h7F, dp: 1'b1, ft: e == 2});
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      got = '{an: an, seg: seg, dp: dp, ft: frame_tick};
      ex  = q.pop_front();
      vec++;
      if (got !== ex) begin
        errs++;
        $display("FAIL rstmid_e%0d got an=%b seg=%h dp=%b ft=%b need an=%b seg=%h dp=%b ft=%b",
                 e, got.an, got.seg, got.dp, got.ft, ex.an, ex.seg, ex.dp, ex.ft);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan(4'b1111, 8, 88, "scan4");
    test_scan(4'b1010, 6, 66, "scan_sparse");
    test_pwm(4'd4, 24);
    test_pwm(4'd0, 0);
    test_pwm(4'd15, 90);
    test_hold();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
